// File: rtl/balance_seq.sv
// Balance-loop sequencer: power-up, rider debounce, soft-start ramp and tilt-fault shutdown.
// Define SOFT_START_EN to build the SOFT_START ramp state; otherwise WAIT_RIDER goes straight to BALANCE.
module balance_seq #(
    parameter int                 RIDER_DB = 4,
    parameter logic signed [15:0] TILT_LIM = 16'sd600,
    parameter int                 TILT_CNT = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pwr_btn,
    input  logic               rider_off,
    input  logic               vld,
    input  logic signed [15:0] ptch,
    input  logic signed [11:0] PID_cntrl,
    input  logic        [7:0]  ss_tmr,
    output logic               pwr_up,
    output logic               rider_off_db,
    output logic signed [11:0] mtr_cmd,
    output logic               tilt_fault
);

    // state      | meaning
    // OFF        | powered down, motor idle
    // WAIT_RIDER | powered, waiting for rider to step on
    // SOFT_START | ramping motor command by ss_tmr/256
    // BALANCE    | full PID command to motor
    // FAULT      | tilt trip latched until button press
    typedef enum logic [2:0] {
        OFF,
        WAIT_RIDER,
`ifdef SOFT_START_EN
        SOFT_START,
`endif
        BALANCE,
        FAULT
    } state_t;

    localparam int RW = $clog2(RIDER_DB) + 1;
    localparam int TW = $clog2(TILT_CNT) + 1;

    state_t          state, nxt;
    logic            btn_q;
    logic [RW-1:0]   rider_cnt;
    logic [TW-1:0]   tilt_cnt;

    logic press, rider_dis, rider_tog, rider_fall, rider_rise;
    logic over, tilt_active, tilt_trip;

    assign press      = pwr_btn & ~btn_q;
    assign rider_dis  = rider_off ^ rider_off_db;
    assign rider_tog  = vld & rider_dis & (rider_cnt == RW'(RIDER_DB - 1));
    assign rider_fall = rider_tog & rider_off_db;
    assign rider_rise = rider_tog & ~rider_off_db;
    assign over       = (ptch > TILT_LIM) || (ptch < -TILT_LIM);

`ifdef SOFT_START_EN
    logic signed [20:0] prod;
    logic signed [11:0] ss_scaled;
    logic               unused_prod_bits;
    // |PID| * 255 < 2^19, so bits [19:8] hold the floored result without overflow
    assign prod             = 21'(PID_cntrl) * 21'($signed({1'b0, ss_tmr}));
    assign ss_scaled        = prod[19:8];
    assign unused_prod_bits = ^{prod[20], prod[7:0]};
    assign tilt_active      = (state == BALANCE) || (state == SOFT_START);
`else
    logic unused_ss_tmr;
    assign unused_ss_tmr = ^ss_tmr;
    assign tilt_active   = (state == BALANCE);
`endif

    assign tilt_trip = tilt_active & vld & over & (tilt_cnt == TW'(TILT_CNT - 1));

    always_comb begin
        nxt = state;
        case (state)
            OFF:        if (press) nxt = WAIT_RIDER;
            WAIT_RIDER: begin
                if (press)
                    nxt = OFF;
                else if (rider_fall)
`ifdef SOFT_START_EN
                    nxt = SOFT_START;
`else
                    nxt = BALANCE;
`endif
            end
`ifdef SOFT_START_EN
            SOFT_START: begin
                if (press)                nxt = OFF;
                else if (tilt_trip)       nxt = FAULT;
                else if (rider_rise)      nxt = WAIT_RIDER;
                else if (ss_tmr == 8'hFF) nxt = BALANCE;
            end
`endif
            BALANCE: begin
                if (press)           nxt = OFF;
                else if (tilt_trip)  nxt = FAULT;
                else if (rider_rise) nxt = WAIT_RIDER;
            end
            FAULT:      if (press) nxt = OFF;
            default:    nxt = OFF;
        endcase
    end

    // Outputs are decoded from the next state so they change together with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= OFF;
            btn_q        <= 1'b0;
            rider_cnt    <= '0;
            rider_off_db <= 1'b1;
            tilt_cnt     <= '0;
            pwr_up       <= 1'b0;
            mtr_cmd      <= '0;
            tilt_fault   <= 1'b0;
        end else begin
            state <= nxt;
            btn_q <= pwr_btn;

            if (!rider_dis) begin
                rider_cnt <= '0;
            end else if (vld) begin
                if (rider_tog) begin
                    rider_cnt    <= '0;
                    rider_off_db <= ~rider_off_db;
                end else begin
                    rider_cnt <= rider_cnt + RW'(1);
                end
            end

            if (nxt != state)
                tilt_cnt <= '0;
            else if (tilt_active && vld)
                tilt_cnt <= over ? tilt_cnt + TW'(1) : '0;

            tilt_fault <= (nxt == FAULT);
            case (nxt)
                BALANCE: begin
                    pwr_up  <= 1'b1;
                    mtr_cmd <= PID_cntrl;
                end
`ifdef SOFT_START_EN
                SOFT_START: begin
                    pwr_up  <= 1'b1;
                    mtr_cmd <= ss_scaled;
                end
`endif
                default: begin
                    pwr_up  <= 1'b0;
                    mtr_cmd <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/balance_seq.md
# balance_seq

Top-level sequencer for the balance loop. It owns power-up, rider detection, soft-start ramping and tilt-fault shutdown. It sits between the inertial interface and the PID datapath:
- drives the PID's `pwr_up` (soft-start timer enable) and `rider_off` (integrator clear) inputs;
- gates and scales `PID_cntrl` into the motor command.

## Interface
Parameters:
- `RIDER_DB`, 4: consecutive `vld` samples needed to accept a rider-on/rider-off change.
- `TILT_LIM`, 16'sd600: pitch magnitude limit; exceeding it counts toward a fault.
- `TILT_CNT`, 8: consecutive `vld` samples over `TILT_LIM` that trip the fault.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pwr_btn`  in  1  power button, synchronous level; edge-detected internally.
- `rider_off`  in  1  raw rider-absent flag from the load cells.
- `vld`  in  1  one-cycle strobe marking a new `ptch` sample.
- `ptch`  in  16  signed pitch.
- `PID_cntrl`  in  12  signed PID output.
- `ss_tmr`  in  8  soft-start timer from the PID.
- `pwr_up`  out  1  enables the PID soft-start timer.
- `rider_off_db`  out  1  debounced rider-absent flag, drives the PID integrator clear.
- `mtr_cmd`  out  12  signed, registered motor command.
- `tilt_fault`  out  1  high while in FAULT.

## Operation
States: OFF, WAIT_RIDER, SOFT_START, BALANCE, FAULT. Reset state is OFF.

Outputs per state:
- OFF: `pwr_up`=0, `mtr_cmd`=0. Button press → WAIT_RIDER.
- WAIT_RIDER: `pwr_up`=0, `mtr_cmd`=0. `rider_off_db` falls → SOFT_START.
- SOFT_START: `pwr_up`=1, `mtr_cmd` = (`PID_cntrl` × {0,`ss_tmr`}) >>> 8.
  - Signed 12×9 multiply into a 21-bit product; take bits [19:8]. Shift rounds toward −∞.
  - Scaled magnitude never exceeds `PID_cntrl`, so no saturation is needed.
  - `ss_tmr`==8'hFF → BALANCE.
- BALANCE: `pwr_up`=1, `mtr_cmd`=`PID_cntrl`.
  - `rider_off_db` rises → WAIT_RIDER.
- FAULT: `pwr_up`=0, `mtr_cmd`=0, `tilt_fault`=1. Button press → OFF. No other exit.

Button handling:
- A press is a 0→1 edge on `pwr_btn`. A held button counts once.
- Press in WAIT_RIDER, SOFT_START or BALANCE → OFF.

Rider debounce:
- Counter advances only on `vld` cycles where raw `rider_off` ≠ `rider_off_db`.
- It clears when they agree.
- `rider_off_db` toggles on the `RIDER_DB`-th consecutive disagreeing sample.
- `rider_off_db` resets to 1.

Tilt detection:
- Active in SOFT_START and BALANCE only.
- A sample is over-limit when `ptch` > `TILT_LIM` or `ptch` < −`TILT_LIM`. 16'h8000 counts as over-limit.
- Counter advances on over-limit `vld` samples and clears on an in-limit `vld`.
- Counter clears on any state change.
- `TILT_CNT`-th consecutive over-limit sample → FAULT.

Priority in one cycle: button press > tilt trip > rider change > `ss_tmr` completion.

## Timing
- All outputs are registered. Reset values: `pwr_up`=0, `rider_off_db`=1, `mtr_cmd`=0, `tilt_fault`=0.
- State transition takes effect the cycle after its causing event; the same registers reflect the new state.
- `mtr_cmd` follows `PID_cntrl`/`ss_tmr` with 1-cycle latency.
- `rider_off_db` changes the cycle after the `RIDER_DB`-th qualifying `vld`.
- On leaving SOFT_START/BALANCE, `pwr_up` falls with the state change, which resets the PID's `ss_tmr`. Re-entry to SOFT_START therefore always restarts the ramp at 0.
- Reset mid-operation returns to OFF within the same cycle (asynchronous); all counters clear.

## Configuration
- `SOFT_START_EN` defined: behaviour as above.
- `SOFT_START_EN` undefined:
  - SOFT_START state and the multiplier are removed.
  - WAIT_RIDER goes directly to BALANCE with `pwr_up`=1.
  - `mtr_cmd`=`PID_cntrl` immediately.

## Test plan
- Reset, then button press, rider_off=0 for 4 `vld` → `rider_off_db`=0 and SOFT_START one cycle later. With `PID_cntrl`=12'sd512, `ss_tmr`=8'h80: `mtr_cmd`=256.
- SOFT_START, `PID_cntrl`=−12'sd3, `ss_tmr`=8'h01 → `mtr_cmd`=−1 (floor). `ss_tmr`=8'hFF → BALANCE, `mtr_cmd`=`PID_cntrl` next cycle.
- BALANCE, `ptch`=601 for 8 `vld` → FAULT, `mtr_cmd`=0, `tilt_fault`=1. Same stimulus with a `ptch`=0 sample at the 7th `vld` → no fault.
- BALANCE, rider_off=1 for 3 `vld`, then 0, then 1 for 4 `vld` → stays BALANCE until the 4th consecutive sample, then WAIT_RIDER, `pwr_up`=0.
- BALANCE, button press coincident with the 8th over-limit `vld` → OFF, not FAULT. Button held for 10 cycles from OFF → single transition to WAIT_RIDER only.
- `SOFT_START_EN` undefined: rider debounce completes → BALANCE directly, `mtr_cmd`=`PID_cntrl` with `ss_tmr`=0.
